// File: rtl/d_tile_l2_if_if.sv
// Request/response bundle between the D-tile L1 controller, this block and the
// on-chip network toward the NUCA L2 tiles.
//   slave  : view used by d_tile_l2_if (accepts D-tile requests and network fills)
//   master : view of the surrounding agents (D-tile + network) driving the block
// Signals:
//   req_*        D-tile request channel (valid/ready)
//   net_req_*    network request channel (valid/ready)
//   net_rsp_*    tagged fill responses from the network
//   rsp_*        fill delivered to the D-tile with original line address
//   wr_ack       writeback acknowledge pulse
//   outstanding  in-flight read count
//   err_bad_tag  sticky error for responses to unknown tags
interface d_tile_l2_if_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned TAG_W      = 2
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_data;
   logic                  net_req_valid;
   logic                  net_req_ready;
   logic                  net_req_write;
   logic [ADDR_WIDTH-1:0] net_req_addr;
   logic [DATA_WIDTH-1:0] net_req_data;
   logic [TAG_W-1:0]      net_req_tag;
   logic                  net_rsp_valid;
   logic [TAG_W-1:0]      net_rsp_tag;
   logic [DATA_WIDTH-1:0] net_rsp_data;
   logic                  rsp_valid;
   logic [ADDR_WIDTH-1:0] rsp_addr;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  wr_ack;
   logic [TAG_W:0]        outstanding;
   logic                  err_bad_tag;

   modport slave (
      input  req_valid, req_write, req_addr, req_data,
      input  net_req_ready, net_rsp_valid, net_rsp_tag, net_rsp_data,
      output req_ready, net_req_valid, net_req_write, net_req_addr, net_req_data, net_req_tag,
      output rsp_valid, rsp_addr, rsp_data, wr_ack, outstanding, err_bad_tag
   );

   modport master (
      output req_valid, req_write, req_addr, req_data,
      output net_req_ready, net_rsp_valid, net_rsp_tag, net_rsp_data,
      input  req_ready, net_req_valid, net_req_write, net_req_addr, net_req_data, net_req_tag,
      input  rsp_valid, rsp_addr, rsp_data, wr_ack, outstanding, err_bad_tag
   );
endinterface

// File: rtl/d_tile_l2_if.sv
// D-tile to NUCA L2 request interface: queues line-fill reads and dirty
// writebacks, issues them to the network in order, tags reads and routes the
// returning fills back to the D-tile with their line address.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   bus        d_tile_l2_if_if.slave (D-tile request, network request/response,
//              fill return, wr_ack, outstanding, err_bad_tag)
// Build option:
//   D_TILE_L2_IF_COALESCE_EN  reads to a line already queued or in flight are
//                             accepted but not sent to the network
module d_tile_l2_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned NUM_TAGS   = 4,
   parameter int unsigned TAG_W      = 2
) (
   input  logic          clk,
   input  logic          rst,
   d_tile_l2_if_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OUT_W = TAG_W + 1;
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(64'h3f);

   if (TAG_W != $clog2(NUM_TAGS)) begin : g_bad_tag_w
      $error("TAG_W must equal clog2(NUM_TAGS)");
   end

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } req_t;

   req_t                  fifo_q [DEPTH];
   req_t                  fifo_d [DEPTH];
   logic [ADDR_WIDTH-1:0] tab_q  [NUM_TAGS];
   logic [ADDR_WIDTH-1:0] tab_d  [NUM_TAGS];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [NUM_TAGS-1:0]   busy_q, busy_d;
   logic                  req_ready_q, req_ready_d;
   logic                  net_req_valid_q, net_req_valid_d;
   logic                  net_req_write_q, net_req_write_d;
   logic [ADDR_WIDTH-1:0] net_req_addr_q, net_req_addr_d;
   logic [DATA_WIDTH-1:0] net_req_data_q, net_req_data_d;
   logic [TAG_W-1:0]      net_req_tag_q, net_req_tag_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  wr_ack_q, wr_ack_d;
   logic [OUT_W-1:0]      outstanding_q, outstanding_d;
   logic                  err_q, err_d;

   logic                  enq, hs, drop, rsp_hit, free_any;
   logic [TAG_W-1:0]      free_tag;
   logic [ADDR_WIDTH-1:0] enq_addr;
   req_t                  head;

   assign enq_addr = bus.req_addr & ~LINE_MASK;

   // Next-state for queue, tag table and all registered outputs.
   always_comb begin
      fifo_d          = fifo_q;
      tab_d           = tab_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      busy_d          = busy_q;
      err_d           = err_q;
      net_req_valid_d = net_req_valid_q;
      net_req_write_d = net_req_write_q;
      net_req_addr_d  = net_req_addr_q;
      net_req_data_d  = net_req_data_q;
      net_req_tag_d   = net_req_tag_q;
      rsp_valid_d     = 1'b0;
      rsp_addr_d      = '0;
      rsp_data_d      = '0;
      wr_ack_d        = 1'b0;
      drop            = 1'b0;
      free_tag        = '0;

`ifdef D_TILE_L2_IF_COALESCE_EN
      // Match against pre-edge in-flight reads and queued reads.
      if (!bus.req_write) begin
         for (int t = 0; t < int'(NUM_TAGS); t++)
            if (busy_q[t] && tab_q[t] == enq_addr) drop = 1'b1;
         for (int i = 0; i < int'(DEPTH); i++)
            if (CNT_W'(i) < count_q &&
                !fifo_q[PTR_W'(rd_ptr_q + PTR_W'(i))].write &&
                fifo_q[PTR_W'(rd_ptr_q + PTR_W'(i))].addr == enq_addr) drop = 1'b1;
      end
`endif

      enq     = bus.req_valid && req_ready_q && !drop;
      hs      = net_req_valid_q && bus.net_req_ready;
      rsp_hit = bus.net_rsp_valid && busy_q[bus.net_rsp_tag];

      if (rsp_hit) begin
         busy_d[bus.net_rsp_tag] = 1'b0;
         rsp_valid_d = 1'b1;
         rsp_addr_d  = tab_q[bus.net_rsp_tag];
         rsp_data_d  = bus.net_rsp_data;
      end else if (bus.net_rsp_valid) begin
         err_d = 1'b1;
      end

      // Presented tag was free before this edge, so it never collides with a freed one.
      if (hs) begin
         rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
         if (net_req_write_q) begin
            wr_ack_d = 1'b1;
         end else begin
            busy_d[net_req_tag_q] = 1'b1;
            tab_d[net_req_tag_q]  = net_req_addr_q;
         end
      end

      if (enq) begin
         fifo_d[wr_ptr_q] = '{write: bus.req_write, addr: enq_addr, data: bus.req_data};
         wr_ptr_d         = PTR_W'(wr_ptr_q + 1'b1);
      end

      count_d       = count_q + CNT_W'(enq) - CNT_W'(hs);
      outstanding_d = outstanding_q + OUT_W'(hs && !net_req_write_q) - OUT_W'(rsp_hit);
      req_ready_d   = count_d < CNT_W'(DEPTH);

      free_any = ~&busy_d;
      for (int t = int'(NUM_TAGS) - 1; t >= 0; t--)
         if (!busy_d[t]) free_tag = TAG_W'(t);

      // A stalled offer keeps its payload and tag; otherwise present the new head.
      head = fifo_d[rd_ptr_d];
      if (!(net_req_valid_q && !bus.net_req_ready)) begin
         net_req_valid_d = (count_d != '0) && (head.write || free_any);
         net_req_write_d = net_req_valid_d && head.write;
         net_req_addr_d  = net_req_valid_d ? head.addr : '0;
         net_req_data_d  = (net_req_valid_d && head.write) ? head.data : '0;
         net_req_tag_d   = (net_req_valid_d && !head.write) ? free_tag : '0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
         for (int t = 0; t < int'(NUM_TAGS); t++) tab_q[t] <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         busy_q          <= '0;
         err_q           <= 1'b0;
         req_ready_q     <= 1'b0;
         net_req_valid_q <= 1'b0;
         net_req_write_q <= 1'b0;
         net_req_addr_q  <= '0;
         net_req_data_q  <= '0;
         net_req_tag_q   <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_addr_q      <= '0;
         rsp_data_q      <= '0;
         wr_ack_q        <= 1'b0;
         outstanding_q   <= '0;
      end else begin
         fifo_q          <= fifo_d;
         tab_q           <= tab_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         busy_q          <= busy_d;
         err_q           <= err_d;
         req_ready_q     <= req_ready_d;
         net_req_valid_q <= net_req_valid_d;
         net_req_write_q <= net_req_write_d;
         net_req_addr_q  <= net_req_addr_d;
         net_req_data_q  <= net_req_data_d;
         net_req_tag_q   <= net_req_tag_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_addr_q      <= rsp_addr_d;
         rsp_data_q      <= rsp_data_d;
         wr_ack_q        <= wr_ack_d;
         outstanding_q   <= outstanding_d;
      end
   end

   assign bus.req_ready     = req_ready_q;
   assign bus.net_req_valid = net_req_valid_q;
   assign bus.net_req_write = net_req_write_q;
   assign bus.net_req_addr  = net_req_addr_q;
   assign bus.net_req_data  = net_req_data_q;
   assign bus.net_req_tag   = net_req_tag_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_addr      = rsp_addr_q;
   assign bus.rsp_data      = rsp_data_q;
   assign bus.wr_ack        = wr_ack_q;
   assign bus.outstanding   = outstanding_q;
   assign bus.err_bad_tag   = err_q;
endmodule
